// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward controller for the five-stage RISC-V pipeline.
// Resolves load-use and control hazards, picks EX operand forwarding sources,
// holds the pipeline during variable-latency data-memory accesses, drains the
// pipeline after reset and latches a sticky error if memory never answers.
// Optional build macro HAZARD_PERF_CNT_EN enables the StallCycles/FlushEvents
// performance counters; without it both ports read as zero.
module hazard_ctrl #(
    parameter int INIT_FLUSH = 2,
    parameter int MAX_WAIT   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic [1:0]  ResultSrcE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        PCSrcE,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        MemTimeout,
    output logic [31:0] StallCycles,
    output logic [31:0] FlushEvents
);

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } state_e;

    // INIT_FLUSH of 0 or 1 both mean a single drain cycle.
    localparam logic [7:0] INIT_LAST  = (INIT_FLUSH > 1) ? 8'(INIT_FLUSH - 1) : 8'd0;
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       load_use;
    logic       mem_wait;

    // M-stage result wins over W-stage result; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic wr_m, input logic [4:0] rd_m,
                                           input logic wr_w, input logic [4:0] rd_w);
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) return 2'b10;
        if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
        return 2'b00;
    endfunction

    // Forwarding is live in every state but forced to the register file while in reset.
    assign ForwardAE = rst_n ? fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW) : 2'b00;
    assign ForwardBE = rst_n ? fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW) : 2'b00;

    assign load_use = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));
    assign mem_wait = MemReqM && !MemReadyM;

    // State and wait/drain counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and hazard outputs; memory waits override load-use and branch handling.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        FlushW     = 1'b0;
        MemTimeout = 1'b0;
        case (state_q)
            ST_INIT: begin
                FlushD = 1'b1;
                FlushE = 1'b1;
                FlushW = 1'b1;
                if (cnt_q == INIT_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_wait) begin
                    // Freeze F..M and feed bubbles into W; held E keeps lw/PCSrcE alive.
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    StallM = 1'b1;
                    FlushW = 1'b1;
                    if (state_q == ST_RUN) begin
                        state_d = ST_MEM_WAIT;
                        cnt_d   = 8'd1;
                    end else if (cnt_q == WAIT_LIMIT) begin
                        state_d = ST_ERROR;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    // A taken branch squashes the load-use stall: the stalled instruction is flushed anyway.
                    StallF  = load_use && !PCSrcE;
                    StallD  = load_use && !PCSrcE;
                    FlushD  = PCSrcE;
                    FlushE  = load_use || PCSrcE;
                    state_d = ST_RUN;
                    cnt_d   = 8'd0;
                end
            end
            ST_ERROR: begin
                StallF     = 1'b1;
                StallD     = 1'b1;
                StallE     = 1'b1;
                StallM     = 1'b1;
                FlushD     = 1'b1;
                FlushE     = 1'b1;
                FlushW     = 1'b1;
                MemTimeout = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = 8'd0;
            end
        endcase
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q, flush_events_q;
    logic        active;
    logic        pc_flush;

    assign active   = (state_q == ST_RUN) || (state_q == ST_MEM_WAIT);
    assign pc_flush = active && !mem_wait && PCSrcE;

    // Performance counters: count only while running, frozen during drain and error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= 32'd0;
            flush_events_q <= 32'd0;
        end else begin
            if (active && StallF) stall_cycles_q <= stall_cycles_q + 32'd1;
            if (pc_flush)         flush_events_q <= flush_events_q + 32'd1;
        end
    end

    assign StallCycles = stall_cycles_q;
    assign FlushEvents = flush_events_q;
`else
    assign StallCycles = 32'd0;
    assign FlushEvents = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, hand sequences for
// memory waits / timeout / async reset, and randomized traffic against a model.
module tb_hazard_ctrl;
    localparam int INIT_FLUSH = 2;
    localparam int MAX_WAIT   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]  ResultSrcE;
    logic        RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] StallCycles, FlushEvents;

    always #5 clk = ~clk;

    hazard_ctrl #(.INIT_FLUSH(INIT_FLUSH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemTimeout(MemTimeout),
        .StallCycles(StallCycles), .FlushEvents(FlushEvents)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: drain cycles left, wait-run length, sticky error, counters.
    int          m_init_left;
    bit          m_err;
    bit          m_in_wait;
    int          m_waits;
    logic [31:0] m_stall;
    logic [31:0] m_flush;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic [1:0] rsrc;
        logic       rwm, rww, pcs;
        logic       sf, fd, fe;
        logic [1:0] fa, fb;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 5'd0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 5'd0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    // {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW,ForwardAE,ForwardBE,MemTimeout}
    function automatic logic [11:0] got_vec();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                ForwardAE, ForwardBE, MemTimeout};
    endfunction

    function automatic logic [11:0] expect_out();
        logic sf, se, fd, fe, fw, to;
        logic [1:0] fa, fb;
        bit lw, mw;
        fa = ref_fwd(Rs1E);
        fb = ref_fwd(Rs2E);
        lw = (ResultSrcE == 2'b01) && (RdE != 5'd0) && (RdE == Rs1D || RdE == Rs2D);
        mw = MemReqM && !MemReadyM;
        sf = 0; se = 0; fd = 0; fe = 0; fw = 0; to = 0;
        if (!rst_n) begin
            fd = 1; fe = 1; fw = 1; fa = 2'b00; fb = 2'b00;
        end else if (m_err) begin
            sf = 1; se = 1; fd = 1; fe = 1; fw = 1; to = 1;
        end else if (m_init_left > 0) begin
            fd = 1; fe = 1; fw = 1;
        end else if (mw) begin
            sf = 1; se = 1; fw = 1;
        end else begin
            sf = lw && !PCSrcE;
            fd = PCSrcE;
            fe = lw || PCSrcE;
        end
        return {sf, sf, se, se, fd, fe, fw, fa, fb, to};
    endfunction

    task automatic model_reset();
        m_init_left = (INIT_FLUSH > 1) ? INIT_FLUSH : 1;
        m_err = 0; m_in_wait = 0; m_waits = 0;
        m_stall = 32'd0; m_flush = 32'd0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic [11:0] e;
        bit mw;
        e  = expect_out();
        mw = MemReqM && !MemReadyM;
        if (!rst_n || m_err) return;
        if (m_init_left > 0) begin
            m_init_left--;
            return;
        end
        if (e[11]) m_stall++;
        if (!mw && PCSrcE) m_flush++;
        if (mw) begin
            if (!m_in_wait) begin
                m_in_wait = 1; m_waits = 1;
            end else if (m_waits == MAX_WAIT) begin
                m_err = 1;
            end else begin
                m_waits++;
            end
        end else begin
            m_in_wait = 0;
        end
    endtask

    task automatic check_model(input string name);
        logic [31:0] exp_sc, exp_fe;
`ifdef HAZARD_PERF_CNT_EN
        exp_sc = m_stall; exp_fe = m_flush;
`else
        exp_sc = 32'd0; exp_fe = 32'd0;
`endif
        chk(name, 32'(got_vec()), 32'(expect_out()));
        chk({name, "_stallcyc"}, StallCycles, exp_sc);
        chk({name, "_flushev"}, FlushEvents, exp_fe);
    endtask

    task automatic cycle_begin(input string name);
        @(negedge clk);
        check_model(name);
    endtask

    task automatic cycle_end();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        ResultSrcE = 2'b00; RegWriteM = 0; RegWriteW = 0; PCSrcE = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    // Asynchronous reset pulse away from any clock edge; returns at posedge+1.
    task automatic do_reset(input string name);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_model(name);
        chk({name, "_nostall"}, 32'({StallF, StallD, StallE, StallM, MemTimeout}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        //            rs1d   rs2d   rs1e   rs2e   rde    rdm    rdw    rsrc   rwm rww pcs  sf fd fe  fa     fb
        vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 2'b00, 1, 1, 0, 0, 0, 0, 2'b10, 2'b00};
        vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 2'b00, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00};
        vecs[2]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd0, 2'b00, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00};
        vecs[3]  = '{5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 5'd9, 5'd0, 2'b00, 1, 0, 0, 0, 0, 0, 2'b00, 2'b10};
        vecs[4]  = '{5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 5'd3, 5'd9, 2'b00, 1, 1, 0, 0, 0, 0, 2'b00, 2'b01};
        vecs[5]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00};
        vecs[6]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00};
        vecs[7]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
        vecs[8]  = '{5'd12, 5'd1, 5'd0, 5'd0, 5'd12, 5'd0, 5'd0, 2'b01, 0, 0, 0, 1, 0, 1, 2'b00, 2'b00};
        vecs[9]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00};
        vecs[10] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 0, 0, 1, 0, 1, 1, 2'b00, 2'b00};
        vecs[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 0, 0, 1, 0, 1, 1, 2'b00, 2'b00};
        vecs[12] = '{5'd0, 5'd0, 5'd4, 5'd4, 5'd0, 5'd4, 5'd4, 2'b00, 1, 1, 0, 0, 0, 0, 2'b10, 2'b10};

        // Reset state, with a forwarding match present that must be masked.
        set_idle();
        Rs1E = 5'd5; RdM = 5'd5; RegWriteM = 1'b1;
        rst_n = 1'b0;
        model_reset();
        #2;
        check_model("reset");
        chk("reset_out", 32'(got_vec()), 32'(12'b0000_1110_0000));
        @(posedge clk); #1;
        @(posedge clk); #1;
        set_idle();
        rst_n = 1'b1;

        // Drain: flushes held for INIT_FLUSH cycles, then released.
        for (int i = 0; i < INIT_FLUSH; i++) begin
            cycle_begin("init");
            chk("init_flush", 32'({FlushD, FlushE, FlushW}), 32'd7);
            cycle_end();
        end
        cycle_begin("run_first");
        chk("run_noflush", 32'({FlushD, FlushE, FlushW}), 32'd0);
        cycle_end();

        // Directed single-cycle vectors in RUN.
        for (int i = 0; i < 13; i++) begin
            set_idle();
            Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d; Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
            RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw; ResultSrcE = vecs[i].rsrc;
            RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww; PCSrcE = vecs[i].pcs;
            cycle_begin($sformatf("vec%0d_model", i));
            chk($sformatf("vec%0d", i),
                32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE}),
                32'({vecs[i].sf, vecs[i].sf, 2'b00, vecs[i].fd, vecs[i].fe, 1'b0, vecs[i].fa, vecs[i].fb}));
            cycle_end();
        end

        // Three-cycle memory wait, released in the ready cycle.
        set_idle();
        MemReqM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle_begin("memwait");
            chk($sformatf("memwait_hold%0d", i),
                32'({StallF, StallD, StallE, StallM, FlushW, MemTimeout}), 32'(6'b111110));
            cycle_end();
        end
        MemReadyM = 1'b1;
        cycle_begin("memready");
        chk("memwait_release", 32'({StallF, StallD, StallE, StallM, FlushW, MemTimeout}), 32'd0);
        cycle_end();

        // Timeout: MAX_WAIT=4 -> decision in the 5th wait cycle, ERROR after it.
        set_idle();
        MemReqM = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle_begin("timeout_wait");
            chk($sformatf("timeout_pending%0d", i), 32'({StallF, StallM, MemTimeout}), 32'(3'b110));
            cycle_end();
        end
        set_idle();
        for (int i = 0; i < 2; i++) begin
            cycle_begin("error");
            chk($sformatf("error_sticky%0d", i),
                32'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout}), 32'hFF);
            cycle_end();
        end
        #2;
        do_reset("err_async_rst");
        for (int i = 0; i < INIT_FLUSH; i++) begin
            cycle_begin("reinit");
            chk("reinit_flush", 32'({FlushD, FlushE, FlushW, MemTimeout}), 32'(4'b1110));
            cycle_end();
        end

        // Randomized traffic: light memory pressure, then heavy pressure that times out.
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i < 300; i++) begin
                Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
                Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
                RdE = 5'($urandom_range(0, 3)); RdM = 5'($urandom_range(0, 3));
                RdW = 5'($urandom_range(0, 3));
                ResultSrcE = 2'($urandom_range(0, 3));
                RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
                PCSrcE = ($urandom_range(0, 3) == 0);
                MemReqM = ($urandom_range(0, 3) < ((round == 0) ? 1 : 3));
                MemReadyM = ($urandom_range(0, 3) >= ((round == 0) ? 1 : 3));
                cycle_begin($sformatf("rand%0d_%0d", round, i));
                cycle_end();
                if (m_err && $urandom_range(0, 3) == 0) do_reset("rand_rst");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush/forward controller for the five-stage RISC-V pipeline.
- Drives stall enables and flush (bubble) controls into the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers.
- Selects the EX-stage operand forwarding sources.
- Sequences variable-latency data-memory waits, the post-reset pipeline drain, and a sticky timeout error state.

Parameters:
- INIT_FLUSH, 2, cycles after reset release during which the D/E/W flushes are held asserted.
- MAX_WAIT, 16, maximum consecutive MEM_WAIT cycles before entering ERROR (legal range 1..255).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Rs1D  in  5  rs1 of the instruction in D.
- Rs2D  in  5  rs2 of the instruction in D.
- Rs1E  in  5  rs1 of the instruction in E.
- Rs2E  in  5  rs2 of the instruction in E.
- RdE  in  5  destination register in E.
- RdM  in  5  destination register in M.
- RdW  in  5  destination register in W.
- ResultSrcE  in  2  result select in E; 2'b01 marks a load.
- RegWriteM  in  1  register write pending in M.
- RegWriteW  in  1  register write pending in W.
- PCSrcE  in  1  branch/jump taken, resolved in E.
- MemReqM  in  1  data-memory access in M.
- MemReadyM  in  1  data memory completes this cycle.
- StallF  out  1  hold the PC.
- StallD  out  1  hold IF/ID.
- StallE  out  1  hold ID/EX.
- StallM  out  1  hold EX/MEM.
- FlushD  out  1  bubble into IF/ID.
- FlushE  out  1  bubble into ID/EX.
- FlushW  out  1  bubble into MEM/WB (write enable and RdW zeroed).
- ForwardAE  out  2  operand A source: 00 register file, 01 W result, 10 M ALU result.
- ForwardBE  out  2  operand B source, same encoding as ForwardAE.
- MemTimeout  out  1  sticky error flag.

Behaviour:
- Registered state: state ∈ {INIT, RUN, MEM_WAIT, ERROR}, 8-bit cnt.
- Outputs are combinational from the state and the current inputs.

Reset (rst_n=0, async):
- state=INIT, cnt=0.
- Outputs: all stalls 0, FlushD=FlushE=FlushW=1, ForwardAE=ForwardBE=00, MemTimeout=0.

Forwarding (every state):
- ForwardAE=10 if RegWriteM & RdM!=0 & RdM==Rs1E.
- Else ForwardAE=01 if RegWriteW & RdW!=0 & RdW==Rs1E.
- Else ForwardAE=00.
- ForwardBE is identical using Rs2E.
- The M match has priority over the W match.

Load-use detect:
- lw = (ResultSrcE==2'b01) & RdE!=0 & (RdE==Rs1D | RdE==Rs2D).

INIT:
- FlushD=FlushE=FlushW=1, stalls 0.
- cnt increments each cycle.
- Go to RUN when cnt==INIT_FLUSH-1, clearing cnt.
- INIT_FLUSH=0 → leave INIT after one cycle.

RUN:
- memwait = MemReqM & ~MemReadyM.
- If memwait:
  - StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
  - lw and PCSrcE are ignored this cycle; they persist because E is held.
  - Next state MEM_WAIT, cnt=1.
- Else:
  - StallF=StallD=lw&~PCSrcE.
  - FlushD=PCSrcE.
  - FlushE=lw|PCSrcE.
  - StallE=StallM=FlushW=0.
  - PCSrcE dominates lw when both are set.

MEM_WAIT:
- Same outputs as the RUN memwait case.
- MemReadyM=1 → outputs take the RUN non-memwait values this cycle; next state RUN, cnt=0.
- Else if cnt==MAX_WAIT → next state ERROR.
- Else cnt increments.
- MemReqM dropping without ready is treated as completion: go to RUN.

ERROR:
- All four stalls 1, FlushD=FlushE=FlushW=1, MemTimeout=1.
- Exited only by reset.

Reset mid-operation:
- Any state goes to INIT immediately on rst_n=0.
- No stall output may remain asserted while in reset.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs StallCycles[31:0], counting cycles with StallF=1 outside INIT.
  - Adds outputs FlushEvents[31:0], counting cycles with PCSrcE-caused FlushD=1.
  - Both counters reset to 0, wrap modulo 2^32, and freeze in ERROR.
- Undefined: the ports are still present and tied to 32'd0, so the interface is unchanged.

Test Plan:
- Reset release, INIT_FLUSH=2, idle inputs → FlushD/E/W=1 for 2 cycles after rst_n rises, then 0; state RUN.
- RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 → ForwardAE=10. Drop RegWriteM → 01. Set RdW=0 → 00.
- ResultSrcE=01, RdE=7, Rs2D=7 → StallF=StallD=1, FlushE=1 for one cycle. Same stimulus with RdE=0 → no stall.
- PCSrcE=1 together with the lw condition → FlushD=FlushE=1, StallF=StallD=0.
- MemReqM=1, MemReadyM=0 for 3 cycles, then MemReadyM=1 → StallF..StallM=1 and FlushW=1 for 3 cycles, released in the ready cycle; MemTimeout=0.
- MemReadyM held 0 with MAX_WAIT=4 → ERROR reached at the 5th wait cycle, MemTimeout=1 sticky; async rst_n pulse mid-cycle → MemTimeout=0 immediately and INIT re-entered.
